// File: rtl/poly_tone_gen.sv
// rtl/poly_tone_gen.sv - polyphonic tone generator with per-voice envelopes and a serial mixer
module poly_tone_gen #(
   parameter int NUM_VOICES   = 8,
   parameter int CLK_HZ       = 50000000,
   parameter int SAMPLE_HZ    = 48000,
   parameter int OUT_W        = 16,
   parameter int ATTACK_STEP  = 16,
   parameter int RELEASE_STEP = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_VOICES-1:0]   btn,
   input  logic                    wave_sel,
   input  logic [2:0]              vol_shift,
   input  logic                    mute,
   output logic signed [OUT_W-1:0] pcm_out,
   output logic                    sample_valid
);

   localparam int DIV   = CLK_HZ / SAMPLE_HZ;
   localparam int CW    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int VW    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam int ACC_W = 16 + $clog2(NUM_VOICES) + 1;
   localparam int SW    = ACC_W + 8;
   localparam int LSH   = (OUT_W >= 16) ? OUT_W - 16 : 0;
   localparam int RSH   = (OUT_W < 16) ? 16 - OUT_W : 0;
   localparam logic signed [SW-1:0] SAT_MAX = SW'((1 << (OUT_W - 1)) - 1);
   localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

   // The mix needs NUM_VOICES+2 cycles plus margin inside one sample period.
   if (DIV < NUM_VOICES + 4) begin : g_div_check
      $error("poly_tone_gen: CLK_HZ/SAMPLE_HZ too small for NUM_VOICES");
   end
   if (NUM_VOICES < 1 || NUM_VOICES > 16 || OUT_W < 12 || OUT_W > 24) begin : g_param_check
      $error("poly_tone_gen: NUM_VOICES or OUT_W out of range");
   end

   typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} vstate_t;

   // Semitone steps above A4, stored for 48 kHz and rescaled for other sample rates.
   function automatic logic [23:0] inc_of(input int v);
      logic [63:0] base;
      case (v)
         0:  base = 64'd153791;  1:  base = 64'd162936;  2:  base = 64'd172625;  3:  base = 64'd182890;
         4:  base = 64'd193765;  5:  base = 64'd205287;  6:  base = 64'd217494;  7:  base = 64'd230426;
         8:  base = 64'd244128;  9:  base = 64'd258645;  10: base = 64'd274025;  11: base = 64'd290319;
         12: base = 64'd307582;  13: base = 64'd325872;  14: base = 64'd345249;  default: base = 64'd365779;
      endcase
      return 24'((base * 64'd48000 + 64'(SAMPLE_HZ / 2)) / 64'(SAMPLE_HZ));
   endfunction

   function automatic logic [7:0] amp_up(input logic [7:0] a);
      int s;
      s = int'(a) + ATTACK_STEP;
      return (s > 255) ? 8'd255 : s[7:0];
   endfunction

   function automatic logic [7:0] amp_dn(input logic [7:0] a);
      int s;
      s = int'(a) - RELEASE_STEP;
      return (s < 0) ? 8'd0 : s[7:0];
   endfunction

   logic [CW-1:0]    div_cnt;
   logic             tick;
   logic             wave_s, mute_s;
   logic [2:0]       vol_s;
   vstate_t          state_q [NUM_VOICES];
   vstate_t          state_d [NUM_VOICES];
   logic [7:0]       amp_q   [NUM_VOICES];
   logic [7:0]       amp_d   [NUM_VOICES];
   logic [23:0]      phase_q [NUM_VOICES];
   logic [23:0]      phase_d [NUM_VOICES];
   logic             busy, done;
   logic [VW-1:0]    vidx;
   logic signed [ACC_W-1:0] acc_q;
   logic [7:0]       cur_top, cur_amp;
   logic signed [7:0]  cur_w;
   logic signed [15:0] cur_vs;
   logic signed [SW-1:0] ext, scaled;
   logic [OUT_W-1:0] sat_val;

   // Sample-rate divider; tick is high for one cycle every DIV cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt <= '0;
         tick    <= 1'b0;
      end else begin
         tick    <= (div_cnt == CW'(DIV - 1));
         div_cnt <= (div_cnt == CW'(DIV - 1)) ? '0 : div_cnt + CW'(1);
      end
   end

   // Per-voice envelope next-state; only committed on the tick edge.
   always_comb begin
      for (int v = 0; v < NUM_VOICES; v++) begin
         state_d[v] = state_q[v];
         amp_d[v]   = amp_q[v];
         phase_d[v] = phase_q[v] + inc_of(v);
         case (state_q[v])
            IDLE: begin
               phase_d[v] = phase_q[v];
               amp_d[v]   = 8'd0;
               if (btn[v]) begin
                  phase_d[v] = 24'd0;
                  amp_d[v]   = amp_up(8'd0);
                  state_d[v] = (amp_up(8'd0) == 8'd255) ? SUSTAIN : ATTACK;
               end
            end
            ATTACK, RELEASE: begin
               if (btn[v]) begin
                  amp_d[v]   = amp_up(amp_q[v]);
                  state_d[v] = (amp_up(amp_q[v]) == 8'd255) ? SUSTAIN : ATTACK;
               end else begin
                  amp_d[v]   = amp_dn(amp_q[v]);
                  state_d[v] = (amp_dn(amp_q[v]) == 8'd0) ? IDLE : RELEASE;
               end
            end
            default: begin
               amp_d[v] = 8'd255;
               if (!btn[v]) begin
                  amp_d[v]   = amp_dn(8'd255);
                  state_d[v] = (amp_dn(8'd255) == 8'd0) ? IDLE : RELEASE;
               end
            end
         endcase
      end
   end

   // Voice state registers and per-sample control snapshot.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int v = 0; v < NUM_VOICES; v++) begin
            state_q[v] <= IDLE;
            amp_q[v]   <= 8'd0;
            phase_q[v] <= 24'd0;
         end
         wave_s <= 1'b0;
         vol_s  <= 3'd0;
         mute_s <= 1'b0;
      end else if (tick) begin
         for (int v = 0; v < NUM_VOICES; v++) begin
            state_q[v] <= state_d[v];
            amp_q[v]   <= amp_d[v];
            phase_q[v] <= phase_d[v];
         end
         wave_s <= wave_sel;
         vol_s  <= vol_shift;
         mute_s <= mute;
      end
   end

   // Sample of the voice currently selected by the mixer.
   always_comb begin
      cur_top = phase_q[vidx][23:16];
      cur_amp = amp_q[vidx];
      if (wave_s) cur_w = $signed(cur_top);
      else        cur_w = cur_top[7] ? -8'sd127 : 8'sd127;
      cur_vs = $signed({{8{cur_w[7]}}, cur_w}) * $signed({8'd0, cur_amp});
      if (state_q[vidx] == IDLE) cur_vs = 16'sd0;
   end

   // Serial mixer: one voice per cycle after each tick.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy  <= 1'b0;
         done  <= 1'b0;
         vidx  <= '0;
         acc_q <= '0;
      end else begin
         done <= 1'b0;
         if (tick) begin
            busy  <= 1'b1;
            vidx  <= '0;
            acc_q <= '0;
         end else if (busy) begin
            acc_q <= acc_q + $signed({{(ACC_W-16){cur_vs[15]}}, cur_vs});
            if (vidx == VW'(NUM_VOICES - 1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end else begin
               vidx <= vidx + VW'(1);
            end
         end
      end
   end

   // Attenuate, align to OUT_W and clip the finished mix.
   always_comb begin
      ext    = $signed({{8{acc_q[ACC_W-1]}}, acc_q}) >>> vol_s;
      scaled = (ext <<< LSH) >>> RSH;
      if (scaled > SAT_MAX)      sat_val = SAT_MAX[OUT_W-1:0];
      else if (scaled < SAT_MIN) sat_val = SAT_MIN[OUT_W-1:0];
      else                       sat_val = scaled[OUT_W-1:0];
   end

   // Output register; holds between samples.
   always_ff @(posedge clk) begin
      if (reset) begin
         pcm_out      <= '0;
         sample_valid <= 1'b0;
      end else begin
         sample_valid <= done;
         if (done) pcm_out <= mute_s ? '0 : sat_val;
      end
   end

endmodule
